// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and register-file types for the MIPS datapath.
package mips_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one asynchronous read port with $zero masking.
// With REG_FILE_BYPASS_EN defined, a same-cycle write to the read address is forwarded.
module reg_file_rd_port
    import mips_pkg::*;
(
    input  reg_addr_t addr_i,
    input  word_t     rdata_i,
`ifdef REG_FILE_BYPASS_EN
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  word_t     wdata_i,
`endif
    output word_t     rd_o
);
`ifdef REG_FILE_BYPASS_EN
    logic hit;
    assign hit  = we_i && (waddr_i != REG_ZERO) && (waddr_i == addr_i);
    assign rd_o = (addr_i == REG_ZERO) ? '0 : hit ? wdata_i : rdata_i;
`else
    assign rd_o = (addr_i == REG_ZERO) ? '0 : rdata_i;
`endif
endmodule

// File: rtl/reg_file.sv
// reg_file: MIPS 3-port register file, two async reads and one sync write; $zero reads 0.
// Optional write-through forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file
    import mips_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  reg_addr_t addr1_i,
    input  reg_addr_t addr2_i,
    input  reg_addr_t addr3_i,
    input  logic      we3_en_i,
    input  word_t     wd3_i,
    output word_t     rd1_o,
    output word_t     rd2_o
);
    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we3_en_i && addr3_i != REG_ZERO) regs_d[addr3_i] = wd3_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) regs_q <= '{default: '0};
        else          regs_q <= regs_d;
    end

    reg_file_rd_port u_rd1 (
        .addr_i  (addr1_i),
        .rdata_i (regs_q[addr1_i]),
`ifdef REG_FILE_BYPASS_EN
        .we_i    (we3_en_i),
        .waddr_i (addr3_i),
        .wdata_i (wd3_i),
`endif
        .rd_o    (rd1_o)
    );

    reg_file_rd_port u_rd2 (
        .addr_i  (addr2_i),
        .rdata_i (regs_q[addr2_i]),
`ifdef REG_FILE_BYPASS_EN
        .we_i    (we3_en_i),
        .waddr_i (addr3_i),
        .wdata_i (wd3_i),
`endif
        .rd_o    (rd2_o)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: vector table, corner sequences and random traffic against an array model.
module tb_reg_file;
    logic        clk;
    logic        rst_n;
    logic [4:0]  a1, a2, a3;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd1, rd2;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] model [32];

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [9];

    reg_file dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .addr1_i  (a1),
        .addr2_i  (a2),
        .addr3_i  (a3),
        .we3_en_i (we),
        .wd3_i    (wd),
        .rd1_o    (rd1),
        .rd2_o    (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && we && a3 == a) return wd;
        return model[a];
    endfunction

    initial begin
        vecs[0] = '{1'b0, 5'd20, 32'h00001010, 5'd20, 5'd20, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd20, 32'h00001010, 5'd20, 5'd20, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 5'd20, 32'h00001010, 5'd20, 5'd20, 32'h00001010, 32'h00001010};
        vecs[3] = '{1'b0, 5'd20, 32'h00001010, 5'd1,  5'd2,  32'h0, 32'h0};
        vecs[4] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd20, 32'h0, 32'h00001010};
        vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd0,  32'hFFFFFFFF, 32'h0};
        vecs[6] = '{1'b1, 5'd20, 32'h12345678, 5'd20, 5'd31, 32'h12345678, 32'hFFFFFFFF};
        vecs[7] = '{1'b0, 5'd20, 32'hxxxxxxxx, 5'd20, 5'd20, 32'h12345678, 32'h12345678};
        vecs[8] = '{1'b1, 5'd1,  32'h0000ABCD, 5'd1,  5'd20, 32'h0000ABCD, 32'h12345678};

        rst_n = 1'b0; we = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd = '0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            chk($sformatf("reset_rd1[%0d]", i), rd1, 32'h0);
            chk($sformatf("reset_rd2[%0d]", 31 - i), rd2, 32'h0);
        end

        for (int i = 0; i < 9; i++) begin
            we = vecs[i].we; a3 = vecs[i].wa; wd = vecs[i].wd;
            a1 = vecs[i].a1; a2 = vecs[i].a2;
            step();
            we = 1'b0;
            #1;
            chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
        end

        we = 1'b1; a3 = 5'd1; wd = 32'h11;
        step();
        a3 = 5'd2; wd = 32'h22;
        step();
        we = 1'b0; a1 = 5'd1; a2 = 5'd2;
        #1;
        chk("fill_reg1", rd1, 32'h11);
        chk("fill_reg2", rd2, 32'h22);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rd1", rd1, 32'h0);
        chk("async_rst_rd2", rd2, 32'h0);
        step();
        we = 1'b1; a3 = 5'd1; wd = 32'h99;
        step();
        we = 1'b0;
        #1;
        chk("write_in_reset", rd1, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("after_release", rd1, 32'h0);

        a1 = 5'd5; a3 = 5'd5; wd = 32'hA5A5A5A5; we = 1'b1;
        #1;
        chk("same_cycle_pre", rd1, BYP ? 32'hA5A5A5A5 : 32'h0);
        step();
        we = 1'b0;
        #1;
        chk("same_cycle_post", rd1, 32'hA5A5A5A5);

        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[5] = 32'hA5A5A5A5;
        for (int c = 0; c < 400; c++) begin
            we = ($urandom_range(0, 2) != 0);
            a3 = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            #1;
            chk("rand_rd1", rd1, expect_rd(a1));
            chk("rand_rd2", rd2, expect_rd(a2));
            step();
            if (we && a3 != 0) model[a3] = wd;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
